// File: rtl/dma_onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_onchip_mem_arbiter_if
// Bundles the two Avalon-MM master ports (m0 = DMA read master, m1 = CPU data
// master) and the single-port RAM s1 port seen by dma_onchip_mem_arbiter.
//   slave  modport : the arbiter's view (masters in, RAM controls out)
//   master modport : the environment's view (masters + RAM model)
// Handshake: a master holds mN_read/mN_write with its address/data; the
// transfer is accepted in any cycle where mN_waitrequest is low. Reads return
// exactly one cycle later as a single-cycle mN_readdatavalid strobe.
// ---------------------------------------------------------------------------
interface dma_onchip_mem_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] m0_address;
   logic [BE_W-1:0]   m0_byteenable;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write,
      output mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write,
      input  mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/dma_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// dma_onchip_mem_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency) between two
// Avalon-MM masters with round-robin arbitration and a bounded hold window.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   reset_req : blocks new grants and drops the RAM clock enable
//   bus       : dma_onchip_mem_arbiter_if.slave (m0, m1 and RAM s1 signals)
// ---------------------------------------------------------------------------
module dma_onchip_mem_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 32,
   parameter int BE_W       = 4,
   parameter int MAX_HOLD   = 4,
   parameter int PRIO_RESET = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     reset_req,
   dma_onchip_mem_arbiter_if.slave  bus
);
   localparam logic [3:0] MAX_HOLD_C   = 4'(MAX_HOLD);
   localparam logic       PRIO_RESET_C = 1'(PRIO_RESET);

   // Arbitration state. hold_cnt == 0 doubles as "nobody was granted last
   // cycle"; otherwise owner is the master granted last cycle and hold_cnt is
   // the length of its current run of consecutive grants.
   logic       prio;
   logic       owner;
   logic [3:0] hold_cnt;
   logic       rd_pend;
   logic       rd_id;

   logic req0, req1;
   logic grant0, grant1, gnt_any, gnt_id, win;
   logic sel_write, sel_read;
   logic [ADDR_W-1:0] sel_address, address_q;
   logic [BE_W-1:0]   sel_byteenable, byteenable_q;
   logic [DATA_W-1:0] sel_writedata, writedata_q;

   always_comb begin
      req0   = bus.m0_read | bus.m0_write;
      req1   = bus.m1_read | bus.m1_write;
      grant0 = 1'b0;
      grant1 = 1'b0;
      win    = prio;
      if (!reset && !reset_req) begin
         if (req0 && !req1) begin
            grant0 = 1'b1;
         end else if (req1 && !req0) begin
            grant1 = 1'b1;
         end else if (req0 && req1) begin
            // Keep the running owner until its window is used up.
            if (hold_cnt != 4'd0 && hold_cnt < MAX_HOLD_C) win = owner;
            else                                            win = prio;
            grant0 = ~win;
            grant1 = win;
         end
      end
   end

   assign gnt_any = grant0 | grant1;
   assign gnt_id  = grant1;

   always_comb begin
      sel_address    = gnt_id ? bus.m1_address    : bus.m0_address;
      sel_byteenable = gnt_id ? bus.m1_byteenable : bus.m0_byteenable;
      sel_writedata  = gnt_id ? bus.m1_writedata  : bus.m0_writedata;
      sel_write      = gnt_id ? bus.m1_write      : bus.m0_write;
      // Read+write together is a write; the read half is dropped.
      sel_read       = (gnt_id ? bus.m1_read : bus.m0_read) & ~sel_write;
   end

   assign bus.m0_waitrequest = ~grant0;
   assign bus.m1_waitrequest = ~grant1;

   // Idle cycles keep the last driven address/data on the RAM bus.
   assign bus.mem_address    = gnt_any ? sel_address    : address_q;
   assign bus.mem_byteenable = gnt_any ? sel_byteenable : byteenable_q;
   assign bus.mem_writedata  = gnt_any ? sel_writedata  : writedata_q;
   assign bus.mem_chipselect = gnt_any;
   assign bus.mem_write      = gnt_any & sel_write;
   assign bus.mem_clken      = ~reset_req;

   assign bus.m0_readdatavalid = rd_pend & ~rd_id;
   assign bus.m1_readdatavalid = rd_pend &  rd_id;
   assign bus.m0_readdata = (rd_pend & ~rd_id) ? bus.mem_readdata : '0;
   assign bus.m1_readdata = (rd_pend &  rd_id) ? bus.mem_readdata : '0;

   always_ff @(posedge clk) begin
      if (gnt_any) begin
         address_q    <= sel_address;
         byteenable_q <= sel_byteenable;
         writedata_q  <= sel_writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio     <= PRIO_RESET_C;
         owner    <= PRIO_RESET_C;
         hold_cnt <= 4'd0;
         rd_pend  <= 1'b0;
         rd_id    <= 1'b0;
      end else begin
         rd_pend <= gnt_any & sel_read;
         if (gnt_any & sel_read) rd_id <= gnt_id;
         if (gnt_any) begin
            prio <= ~gnt_id;
            if (gnt_id == owner && hold_cnt != 4'd0) begin
               if (hold_cnt != 4'hF) hold_cnt <= hold_cnt + 4'd1;
            end else begin
               owner    <= gnt_id;
               hold_cnt <= 4'd1;
            end
         end else begin
            hold_cnt <= 4'd0;
         end
      end
   end
endmodule

// File: tb/tb_dma_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_onchip_mem_arbiter
// Drives both masters, models the RAM behind s1, and checks grants, RAM-side
// controls and read returns against a reference model of the sharing rules.
// ---------------------------------------------------------------------------
module tb_dma_onchip_mem_arbiter;
   localparam int ADDR_W = 17, DATA_W = 32, BE_W = 4, MAX_HOLD = 4, PRIO_RESET = 0;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic reset_req;
   always #5 clk = ~clk;

   dma_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

   dma_onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
      .MAX_HOLD(MAX_HOLD), .PRIO_RESET(PRIO_RESET)
   ) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req), .bus(bus)
   );

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // ---------------- RAM model (s1 port, clken gates everything) ----------------
   logic [31:0] ram [logic [16:0]];
   logic [31:0] ram_q = '0;
   assign bus.mem_readdata = ram_q;
   always @(posedge clk) begin
      if (bus.mem_clken && bus.mem_chipselect) begin
         if (bus.mem_write)
            ram[bus.mem_address] = merge(ram.exists(bus.mem_address) ? ram[bus.mem_address] : '0,
                                         bus.mem_writedata, bus.mem_byteenable);
         else
            ram_q <= ram.exists(bus.mem_address) ? ram[bus.mem_address] : '0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          cyc;
      int          g;
      logic        wr;
      logic [16:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      logic        clken;
   } gnt_t;
   typedef struct {
      int          due;
      int          id;
      logic [31:0] data;
   } rd_t;
   gnt_t grant_q[$];
   rd_t  rd_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [logic [16:0]];
   int m_prio = PRIO_RESET;
   int m_last = -1;   // master granted in the previous cycle, -1 if none
   int m_run  = 0;    // consecutive grants of m_last
   int cyc_n  = 0;

   function automatic logic [31:0] ref_rd(logic [16:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   // Predicts this cycle's outcome from the driven inputs, queues it, then
   // advances one clock.
   task automatic step();
      gnt_t e;
      rd_t  r;
      logic req0, req1, rd;
      int   g;
      req0 = bus.m0_read | bus.m0_write;
      req1 = bus.m1_read | bus.m1_write;
      g = -1;
      if (!reset && !reset_req) begin
         if (req0 && !req1)      g = 0;
         else if (req1 && !req0) g = 1;
         else if (req0 && req1)  g = (m_last >= 0 && m_run < MAX_HOLD) ? m_last : m_prio;
      end
      e.cyc = cyc_n; e.g = g; e.clken = ~reset_req;
      e.wr = 1'b0; e.a = '0; e.be = '0; e.d = '0; rd = 1'b0;
      if (g == 0) begin
         e.wr = bus.m0_write; rd = bus.m0_read; e.a = bus.m0_address;
         e.be = bus.m0_byteenable; e.d = bus.m0_writedata;
      end else if (g == 1) begin
         e.wr = bus.m1_write; rd = bus.m1_read; e.a = bus.m1_address;
         e.be = bus.m1_byteenable; e.d = bus.m1_writedata;
      end
      if (g >= 0) begin
         if (e.wr) begin
            ref_mem[e.a] = merge(ref_rd(e.a), e.d, e.be);
         end else if (rd) begin
            r.due = cyc_n + 1; r.id = g; r.data = ref_rd(e.a);
            rd_q.push_back(r);
         end
         if (m_last == g) m_run = (m_run < 15) ? m_run + 1 : 15;
         else begin m_last = g; m_run = 1; end
         m_prio = 1 - g;
      end else begin
         m_last = -1; m_run = 0;
      end
      if (reset) begin
         m_prio = PRIO_RESET; m_last = -1; m_run = 0;
      end
      grant_q.push_back(e);
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_m(input int n, input logic rd, input logic wr, input logic [16:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      if (n == 0) begin
         bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
         bus.m0_byteenable = be; bus.m0_writedata = d;
      end else begin
         bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
         bus.m1_byteenable = be; bus.m1_writedata = d;
      end
   endtask

   task automatic idle_both();
      set_m(0, 1'b0, 1'b0, '0, '0, '0);
      set_m(1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      idle_both();
      repeat (n) step();
      reset = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      gnt_t e;
      rd_t  r;
      logic v0, v1;
      if (grant_q.size() > 0) begin
         e = grant_q.pop_front();
         check("m0_waitrequest", e.cyc, 32'(bus.m0_waitrequest), 32'(e.g != 0));
         check("m1_waitrequest", e.cyc, 32'(bus.m1_waitrequest), 32'(e.g != 1));
         check("mem_clken",      e.cyc, 32'(bus.mem_clken),      32'(e.clken));
         check("mem_chipselect", e.cyc, 32'(bus.mem_chipselect), 32'(e.g >= 0));
         check("mem_write",      e.cyc, 32'(bus.mem_write),      32'(e.g >= 0 && e.wr));
         if (e.g >= 0) begin
            check("mem_address",    e.cyc, 32'(bus.mem_address),    32'(e.a));
            check("mem_byteenable", e.cyc, 32'(bus.mem_byteenable), 32'(e.be));
            if (e.wr) check("mem_writedata", e.cyc, bus.mem_writedata, e.d);
         end
         v0 = bus.m0_readdatavalid;
         v1 = bus.m1_readdatavalid;
         if (v0 || v1) begin
            if (rd_q.size() == 0) begin
               check("rdv_unexpected", e.cyc, 32'({v1, v0}), 32'd0);
            end else begin
               r = rd_q.pop_front();
               check("rdv_both",  e.cyc, 32'(v0 & v1), 32'd0);
               check("rdv_cycle", e.cyc, 32'(e.cyc), 32'(r.due));
               check("rdv_id",    e.cyc, 32'(v1), 32'(r.id));
               check("readdata",  e.cyc, v1 ? bus.m1_readdata : bus.m0_readdata, r.data);
            end
         end else if (rd_q.size() > 0 && rd_q[0].due <= e.cyc) begin
            r = rd_q.pop_front();
            check("rdv_missing", e.cyc, 32'(v0 | v1), 32'd1);
         end
         if (!v0) check("m0_readdata_idle", e.cyc, bus.m0_readdata, '0);
         if (!v1) check("m1_readdata_idle", e.cyc, bus.m1_readdata, '0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin : driver
      reset = 1'b1;
      reset_req = 1'b0;
      idle_both();
      @(posedge clk);
      #1;
      do_reset(3);

      // write then read back on m0
      set_m(0, 1'b0, 1'b1, 17'h00010, 4'hF, 32'hDEADBEEF); step();
      set_m(0, 1'b1, 1'b0, 17'h00010, 4'hF, 32'h0);        step();
      idle_both(); step();

      // both masters reading continuously from reset: hold window rotation
      do_reset(2);
      for (int i = 0; i < 18; i++) begin
         set_m(0, 1'b1, 1'b0, 17'($urandom_range(0, 31)), 4'hF, '0);
         set_m(1, 1'b1, 1'b0, 17'($urandom_range(0, 31)), 4'hF, '0);
         step();
      end
      idle_both(); step();

      // m1 alone for 10 cycles
      for (int i = 0; i < 10; i++) begin
         set_m(1, 1'($urandom_range(0, 1)), 1'b0, 17'($urandom_range(0, 31)), 4'hF, '0);
         bus.m1_read = 1'b1;
         step();
      end
      idle_both(); step();

      // partial byte write from m1, read back by m0
      set_m(1, 1'b0, 1'b1, 17'h00020, 4'hF, 32'hAAAAAAAA); step();
      set_m(1, 1'b0, 1'b1, 17'h00020, 4'h3, 32'h12345678); step();
      idle_both();
      set_m(0, 1'b1, 1'b0, 17'h00020, 4'hF, '0); step();
      idle_both(); step();

      // reset_req arrives right after an accepted m0 read
      set_m(0, 1'b1, 1'b0, 17'h00010, 4'hF, '0); step();
      idle_both();
      reset_req = 1'b1;
      set_m(1, 1'b1, 1'b0, 17'h00020, 4'hF, '0);
      repeat (3) step();
      reset_req = 1'b0;
      step();
      idle_both(); step();

      // read and write together on m0: write wins, no read return
      set_m(0, 1'b1, 1'b1, 17'h00030, 4'hF, 32'h00000055); step();
      set_m(0, 1'b1, 1'b0, 17'h00030, 4'hF, '0);           step();
      idle_both(); step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < 2; n++) begin
            if ($urandom_range(0, 9) < 7)
               set_m(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                     17'({$urandom_range(0, 1), 11'd0, 5'($urandom_range(0, 31))}),
                     4'($urandom_range(1, 15)), $urandom);
            else
               set_m(n, 1'b0, 1'b0, '0, '0, '0);
         end
         reset_req = ($urandom_range(0, 19) == 0);
         step();
      end
      reset_req = 1'b0;
      idle_both();
      repeat (3) step();

      // drain with a bounded wait
      for (int i = 0; i < 20 && grant_q.size() > 0; i++) @(posedge clk);
      #1;
      check("grant_q_drained", cyc_n, 32'(grant_q.size()), 32'd0);
      check("rd_q_drained",    cyc_n, 32'(rd_q.size()),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
